// File: rtl/mdu_if.sv
// Handshake bundle between decode/execute and the iterative multiply/divide unit.
// The unit itself connects through the slave modport.
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand_a, operand_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: one shared 32-step shift-add / restoring-divide datapath
// working on operand magnitudes, with sign fix-up applied when the result is latched.
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] fix_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] result_q;
    logic            neg_q;
    logic            rneg_q;
    logic [CW-1:0]   cnt_q;

    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic            accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi;
    logic [XLEN-1:0]   mul_lo;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_hi;
    logic [XLEN-1:0]   div_lo;
    logic [XLEN-1:0]   hi_step;
    logic [XLEN-1:0]   lo_step;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_val;

    // Operand decode on the incoming request: signedness, magnitudes and fast-path cases.
    always_comb begin
        is_div   = bus.op[2];
        a_signed = (~bus.op[2] & (bus.op[1] ^ bus.op[0])) | (bus.op[2] & ~bus.op[0]);
        b_signed = (bus.op == 3'b001) | (bus.op[2] & ~bus.op[0]);
        sign_a   = a_signed & bus.operand_a[XLEN-1];
        sign_b   = b_signed & bus.operand_b[XLEN-1];
        a_mag    = sign_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
        b_mag    = sign_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
        div_zero = is_div & (bus.operand_b == '0);
        div_ovf  = is_div & ~bus.op[0] & (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.operand_b == '1);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_val = bus.op[1] ? bus.operand_a : '1;
        else
            special_val = bus.op[1] ? '0 : bus.operand_a;
        accept = bus.start & ~bus.kill;
    end

    // One iteration of either algorithm; the op captured at accept selects which one.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, fix_q} : '0);
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, fix_q};
        div_hi    = div_ge ? (div_shift[XLEN-1:0] - fix_q) : div_shift[XLEN-1:0];
        div_lo    = {lo_q[XLEN-2:0], div_ge};
        hi_step   = op_q[2] ? div_hi : mul_hi;
        lo_step   = op_q[2] ? div_lo : mul_lo;
        prod_s    = neg_q ? (~{hi_step, lo_step} + 1'b1) : {hi_step, lo_step};
        mul_res   = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quot      = neg_q ? (~lo_step + 1'b1) : lo_step;
        rem       = rneg_q ? (~hi_step + 1'b1) : hi_step;
        final_val = op_q[2] ? (op_q[1] ? rem : quot) : mul_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? FIN : CALC;
            end
            CALC: begin
                if (bus.kill)
                    state_nxt = IDLE;
                else if (cnt_q == LAST)
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result is written only on the edge entering FIN, so a kill leaves the old value in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            fix_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.op;
                        neg_q  <= sign_a ^ sign_b;
                        rneg_q <= sign_a;
                        cnt_q  <= '0;
                        hi_q   <= '0;
                        fix_q  <= is_div ? b_mag : a_mag;
                        lo_q   <= is_div ? a_mag : b_mag;
                        if (special)
                            result_q <= special_val;
                    end
                end
                CALC: begin
                    if (!bus.kill) begin
                        hi_q  <= hi_step;
                        lo_q  <= lo_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST)
                            result_q <= final_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FIN) & ~bus.kill;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed-vector bench for mdu_iterative: RV32M results, latency, start-while-busy,
// kill and asynchronous reset behaviour.
module tb_mdu_iterative;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   done_seen;

    mdu_if #(.XLEN(32)) bus ();

    mdu_iterative #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge, count cycles to done, then check the pulse ends cleanly.
    // A nonzero poke cycle pulses a conflicting DIVU request while the unit is busy.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int exp_lat, input int poke);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.op        = 3'b110;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h1234_5678;
        cyc = 1;
        while (!bus.done && cyc < 60) begin
            if (cyc == poke) begin
                bus.start     = 1'b1;
                bus.op        = OP_DIVU;
                bus.operand_a = 32'd100;
                bus.operand_b = 32'd7;
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        checkOutput({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        checkOutput({tag, "_res"}, bus.result, exp);
        @(negedge clk);
        checkOutput({tag, "_done1"}, {31'b0, bus.done}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.op        = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        rst = 1'b0;

        applyStimulus("mul",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        applyStimulus("mulhu",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        applyStimulus("mulh",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
        applyStimulus("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 0);
        applyStimulus("div",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
        applyStimulus("rem",     OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
        applyStimulus("divu",    OP_DIVU,   32'd100,        32'd7,         32'd14,        33, 0);
        applyStimulus("remu",    OP_REMU,   32'd100,        32'd7,         32'd2,         33, 0);
        applyStimulus("divu0",   OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
        applyStimulus("rem0",    OP_REM,    32'd5,          32'd0,         32'd5,         1,  0);
        applyStimulus("div_ovf", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        applyStimulus("rem_ovf", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);

        // A start pulse at cycle 10 of a MUL must not disturb it or queue a second op.
        applyStimulus("mul_poke", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 10);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checkOutput("poke_nodone", 32'(done_seen), 32'd0);

        // Kill a DIVU at cycle 5: unit idles next cycle, no done, result keeps the MUL value.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checkOutput("kill_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("kill_done", {31'b0, bus.done}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checkOutput("kill_nodone", 32'(done_seen), 32'd0);
        checkOutput("kill_result", bus.result, 32'hFFFF_FFEB);

        // kill together with start in IDLE drops the request.
        bus.start     = 1'b1;
        bus.kill      = 1'b1;
        bus.op        = OP_DIVU;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        checkOutput("idlekill_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("idlekill_done", {31'b0, bus.done}, 32'd0);
        checkOutput("idlekill_result", bus.result, 32'hFFFF_FFEB);

        // Asynchronous reset in the middle of a MUL clears outputs without waiting for an edge.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = OP_MUL;
        bus.operand_a = 32'd7;
        bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        checkOutput("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("arst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("arst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit for the RV32M extension, in the execute stage directly downstream of the register bank.
- Consumes operand_a/operand_b from register read and the decoded funct3, and returns a 32-bit result to writeback.
- Uses one shared 32-iteration shift-add / restoring-divide datapath.
- Decode holds the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- ITER, 32, iteration count. Must equal XLEN.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request valid. Sampled only in IDLE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  32  rs1 value (multiplicand/dividend). Captured on accept.
- operand_b  in  32  rs2 value (multiplier/divisor). Captured on accept.
- kill  in  1  synchronous flush. Aborts the current op.
- busy  out  1  high in CALC and FIN.
- done  out  1  one-cycle pulse, high in FIN.
- result  out  32  final value. Valid while done is high; held until the next FIN.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0; counter, accumulators and captured operands cleared.
- States:
  - IDLE: on start, capture op, operand_a, operand_b and sign flags. If the op is a special case, go to FIN; otherwise go to CALC with counter=0.
  - CALC: one iteration per clock. At counter==31, go to FIN.
  - FIN: done=1. The FIN entry edge registers result. Next edge goes to IDLE.
- Latency, with the start cycle as cycle 0: normal ops give done in cycle 33; special cases give done in cycle 1. done stays high exactly one cycle.
- A new start is accepted only in IDLE. A start seen in the FIN cycle is ignored. start while busy is ignored; it is neither queued nor allowed to corrupt state.
- kill (synchronous):
  - In CALC or FIN, go to IDLE next edge with no done pulse; result is unchanged.
  - In IDLE, kill has priority over start, and start is dropped.
- Multiply:
  - Signed operands use magnitudes; an unsigned 64-bit shift-add product is built from them.
  - Signedness: MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned.
  - Negate the product if the sign flags differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring divide on magnitudes: 33-bit trial subtraction of the remainder shifted left with the next dividend bit. Quotient bit = no-borrow.
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
  - The divisor sign is ignored for the unsigned variants.
- Special cases (fast path, no iteration):
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - DIV overflow, 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- All arithmetic is modulo 2^32 on result. There are no exceptions or flags.

Test Plan:
- MUL: a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done in cycle 33. MULHU: a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- MULH: a=b=0x80000000 -> 0x40000000. MULHSU: a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV: a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU: a=100, b=7 -> 14. REMU with the same operands -> 2.
- Divide by zero:
  - DIVU: a=5, b=0 -> 0xFFFFFFFF, with done in cycle 1.
  - REM: a=5, b=0 -> 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Both with done in cycle 1.
- Control:
  - start pulsed at cycle 10 of a MUL -> ignored, and the original result is unchanged.
  - kill at cycle 5 -> no done, busy=0 next cycle.
  - rst asserted mid-CALC -> busy, done and result read 0 immediately.
  - A new DIVU started after recovery completes correctly.
